// File: rtl/router_reg.sv
// router_reg: datapath register stage behind the 1x3 router FSM.
// Latches the header, parks the byte seen while the FIFO is full, and checks running XOR parity.
module router_reg #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          packet_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          lfd_state,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          rst_int_reg,
    output logic [DW-1:0] dout,
    output logic          parity_done,
    output logic          low_packet_valid,
    output logic          err
);
    logic [DW-1:0] r_dout, r_hdr, r_full_hold, r_int_parity, r_pkt_parity;
    logic          r_parity_done, r_low_packet_valid, r_err;
    logic          w_bad_addr, w_pcap_ld, w_pcap_laf;

    // A header addressed to port 3 is ignored outright: no register moves that cycle.
    assign w_bad_addr = detect_add && (data_in[1:0] == 2'b11);
    assign w_pcap_ld  = ld_state && !packet_valid && !fifo_full;
    assign w_pcap_laf = laf_state && r_low_packet_valid && !r_parity_done;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dout             <= '0;
            r_hdr              <= '0;
            r_full_hold        <= '0;
            r_int_parity       <= '0;
            r_pkt_parity       <= '0;
            r_parity_done      <= 1'b0;
            r_low_packet_valid <= 1'b0;
            r_err              <= 1'b0;
        end else if (!w_bad_addr) begin
            if (detect_add && packet_valid)
                r_hdr <= data_in;
            if (lfd_state)
                r_dout <= r_hdr;
            else if (ld_state && !fifo_full)
                r_dout <= data_in;
            else if (laf_state)
                r_dout <= r_full_hold;
            if (ld_state && fifo_full)
                r_full_hold <= data_in;
            if (detect_add)
                r_int_parity <= '0;
            else if (lfd_state)
                r_int_parity <= r_int_parity ^ r_hdr;
            else if (ld_state && packet_valid && !full_state && !fifo_full)
                r_int_parity <= r_int_parity ^ data_in;
            else if (laf_state && !r_parity_done && !r_low_packet_valid)
                r_int_parity <= r_int_parity ^ r_full_hold;
            if (detect_add)
                r_pkt_parity <= '0;
            else if (w_pcap_ld)
                r_pkt_parity <= data_in;
            else if (w_pcap_laf)
                r_pkt_parity <= r_full_hold;
            if (detect_add)
                r_parity_done <= 1'b0;
            else if (w_pcap_ld || w_pcap_laf)
                r_parity_done <= 1'b1;
            if (rst_int_reg)
                r_low_packet_valid <= 1'b0;
            else if (ld_state && !packet_valid)
                r_low_packet_valid <= 1'b1;
            if (detect_add)
                r_err <= 1'b0;
            else if (rst_int_reg && r_parity_done)
                r_err <= (r_int_parity != r_pkt_parity);
        end
    end

    assign dout             = r_dout;
    assign parity_done      = r_parity_done;
    assign low_packet_valid = r_low_packet_valid;
    assign err              = r_err;
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: packet-level bench for router_reg; expected bytes and parity verdicts come from whole packets.
module tb_router_reg;
    logic       clock = 1'b0;
    logic       resetn, packet_valid, fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] data_in, dout;
    logic       parity_done, low_packet_valid, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pl_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    logic       obs_pdone, obs_low, obs_err, obs_low_after;

    router_reg #(.DW(8)) dut (
        .clock(clock), .resetn(resetn), .packet_valid(packet_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
        .low_packet_valid(low_packet_valid), .err(err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
        full_state = 0; rst_int_reg = 0; fifo_full = 0;
    endtask

    // Reference: a packet is written out verbatim and its parity byte must equal the XOR of header and payload.
    task automatic build_expect(input logic [7:0] h, input logic [7:0] par, output logic exp_err);
        logic [7:0] x;
        x = h;
        exp_q.delete();
        exp_q.push_back(h);
        foreach (pl_q[i]) begin
            exp_q.push_back(pl_q[i]);
            x = x ^ pl_q[i];
        end
        exp_q.push_back(par);
        exp_err = (x != par);
    endtask

    // Plays the FSM strobes for one packet; full_at selects the byte (payload index or pl_q.size() for parity) that meets a full FIFO.
    task automatic run_packet(input logic [7:0] h, input logic [7:0] par, input int full_at);
        bit last;
        obs_q.delete();
        idle(); detect_add = 1; packet_valid = 1; data_in = h; tick();
        idle(); lfd_state = 1; data_in = 8'($urandom); tick();
        obs_q.push_back(dout);
        for (int i = 0; i <= pl_q.size(); i++) begin
            last = (i == pl_q.size());
            idle(); ld_state = 1; packet_valid = !last; fifo_full = (i == full_at);
            if (last) data_in = par; else data_in = pl_q[i];
            tick();
            if (i == full_at) begin
                idle(); full_state = 1; fifo_full = 1; data_in = 8'($urandom); tick();
                idle(); laf_state = 1; tick();
            end
            obs_q.push_back(dout);
        end
        obs_pdone = parity_done;
        obs_low   = low_packet_valid;
        idle(); packet_valid = 0; rst_int_reg = 1; tick();
        obs_err       = err;
        obs_low_after = low_packet_valid;
        idle();
    endtask

    task automatic test_reset();
        idle(); packet_valid = 0; data_in = 8'hA5; resetn = 0;
        tick(); tick();
        n_checks += 4;
        if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
        if (parity_done !== 1'b0) begin n_fail++; $display("FAIL reset_pdone: got %b expected 0", parity_done); end
        if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset_low: got %b expected 0", low_packet_valid); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        resetn = 1;
        tick();
    endtask

    task automatic test_clean_packet();
        logic e;
        pl_q = '{8'h11, 8'h22, 8'h33};
        build_expect(8'h0D, 8'h0D, e);
        run_packet(8'h0D, 8'h0D, -1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clean_dout[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks += 4;
        if (obs_pdone !== 1'b1) begin n_fail++; $display("FAIL clean_pdone: got %b expected 1", obs_pdone); end
        if (obs_low !== 1'b1) begin n_fail++; $display("FAIL clean_low: got %b expected 1", obs_low); end
        if (obs_err !== e) begin n_fail++; $display("FAIL clean_err: got %b expected %b", obs_err, e); end
        if (obs_low_after !== 1'b0) begin n_fail++; $display("FAIL clean_low_cleared: got %b expected 0", obs_low_after); end
    endtask

    task automatic test_bad_parity();
        logic e;
        pl_q = '{8'h11, 8'h22, 8'h33};
        build_expect(8'h0D, 8'h0C, e);
        run_packet(8'h0D, 8'h0C, -1);
        n_checks += 2;
        if (obs_err !== e) begin n_fail++; $display("FAIL bad_err: got %b expected %b", obs_err, e); end
        if (obs_q[4] !== 8'h0C) begin n_fail++; $display("FAIL bad_dout_parity: got %h expected 0c", obs_q[4]); end
        // next header arrives together with another parity check: the header must clear err
        idle(); detect_add = 1; rst_int_reg = 1; packet_valid = 1; data_in = 8'h0D; tick();
        n_checks += 2;
        if (err !== 1'b0) begin n_fail++; $display("FAIL bad_err_cleared: got %b expected 0", err); end
        if (parity_done !== 1'b0) begin n_fail++; $display("FAIL bad_pdone_cleared: got %b expected 0", parity_done); end
        idle();
    endtask

    task automatic test_full_payload();
        logic e;
        pl_q = '{8'h11, 8'h22, 8'h33};
        build_expect(8'h0D, 8'h0D, e);
        run_packet(8'h0D, 8'h0D, 1);
        n_checks += obs_q.size() == exp_q.size() ? 0 : 1;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fullp_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fullp_dout[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_err !== e) begin n_fail++; $display("FAIL fullp_err: got %b expected %b", obs_err, e); end
    endtask

    task automatic test_full_parity();
        logic e;
        pl_q = '{8'h11, 8'h22, 8'h33};
        build_expect(8'h0D, 8'h0D, e);
        run_packet(8'h0D, 8'h0D, 3);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fullpar_dout[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks += 2;
        if (obs_pdone !== 1'b1) begin n_fail++; $display("FAIL fullpar_pdone: got %b expected 1", obs_pdone); end
        if (obs_err !== e) begin n_fail++; $display("FAIL fullpar_err: got %b expected %b", obs_err, e); end
    endtask

    task automatic test_addr3();
        logic e;
        pl_q = '{8'hAA};
        build_expect(8'h05, 8'hAF, e);
        run_packet(8'h05, 8'hAF, -1);
        idle(); detect_add = 1; packet_valid = 1; data_in = 8'h0F; tick();
        n_checks += 3;
        if (dout !== 8'hAF) begin n_fail++; $display("FAIL addr3_dout: got %h expected af", dout); end
        if (parity_done !== 1'b1) begin n_fail++; $display("FAIL addr3_pdone: got %b expected 1", parity_done); end
        if (err !== e) begin n_fail++; $display("FAIL addr3_err: got %b expected %b", err, e); end
        idle(); lfd_state = 1; tick();
        n_checks++;
        if (dout !== 8'h05) begin n_fail++; $display("FAIL addr3_hdr_kept: got %h expected 05", dout); end
        idle();
    endtask

    task automatic test_async_reset();
        logic e;
        idle(); detect_add = 1; packet_valid = 1; data_in = 8'h0D; tick();
        idle(); lfd_state = 1; tick();
        idle(); ld_state = 1; data_in = 8'h11; tick();
        idle(); ld_state = 1; packet_valid = 0; data_in = 8'h3C; tick();
        #2 resetn = 0;
        #1;
        n_checks += 4;
        if (dout !== 8'h00) begin n_fail++; $display("FAIL arst_dout: got %h expected 00", dout); end
        if (parity_done !== 1'b0) begin n_fail++; $display("FAIL arst_pdone: got %b expected 0", parity_done); end
        if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL arst_low: got %b expected 0", low_packet_valid); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b expected 0", err); end
        tick();
        resetn = 1;
        idle(); lfd_state = 1; tick();
        n_checks++;
        if (dout !== 8'h00) begin n_fail++; $display("FAIL arst_hdr_cleared: got %h expected 00", dout); end
        idle();
        pl_q = '{8'h11, 8'h22, 8'h33};
        build_expect(8'h0D, 8'h0D, e);
        run_packet(8'h0D, 8'h0D, -1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL arst_pkt_dout[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_err !== e) begin n_fail++; $display("FAIL arst_pkt_err: got %b expected %b", obs_err, e); end
    endtask

    task automatic test_random();
        logic       e;
        logic [7:0] h, par;
        int         len, full_at;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 12);
            h = {6'(len), 2'($urandom_range(0, 2))};
            pl_q.delete();
            for (int k = 0; k < len; k++) pl_q.push_back(8'($urandom));
            par = h;
            foreach (pl_q[k]) par = par ^ pl_q[k];
            if ($urandom_range(0, 1) == 1) par = par ^ 8'($urandom_range(1, 255));
            full_at = $urandom_range(0, 2) == 0 ? -1 : $urandom_range(0, len);
            build_expect(h, par, e);
            run_packet(h, par, full_at);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_dout[%0d]: got %h expected %h", p, i, obs_q[i], exp_q[i]); end
            end
            n_checks += 3;
            if (obs_pdone !== 1'b1) begin n_fail++; $display("FAIL rand%0d_pdone: got %b expected 1", p, obs_pdone); end
            if (obs_err !== e) begin n_fail++; $display("FAIL rand%0d_err: got %b expected %b", p, obs_err, e); end
            if (obs_low_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_low: got %b expected 0", p, obs_low_after); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_packet();
        test_bad_parity();
        test_full_payload();
        test_full_parity();
        test_addr3();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage directly downstream of the 1x3 router control FSM: it consumes the FSM state strobes and turns the raw `data_in` byte stream into the byte written to the selected output FIFO. It latches the header, handles the one byte that arrives while the FIFO is full, and accumulates running XOR parity over header and payload. It returns `parity_done` and `low_packet_valid` to the FSM and flags `err` when the received parity byte does not match.

## Interface
Parameters:
- `DW`, 8, data byte width; header layout is `[DW-1:2]` payload length, `[1:0]` destination address.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `packet_valid`  in  1  source packet framing; high through header and payload, low on the parity byte.
- `data_in`  in  DW  source byte.
- `fifo_full`  in  1  full flag of the currently selected FIFO.
- `detect_add`  in  1  FSM: header accepted this cycle.
- `lfd_state`  in  1  FSM: Load_first_data.
- `ld_state`  in  1  FSM: Load_data.
- `laf_state`  in  1  FSM: Load_after_full.
- `full_state`  in  1  FSM: Fifo_full_state.
- `rst_int_reg`  in  1  FSM: Check_parity_error.
- `dout`  out  DW  byte presented to FIFO write port.
- `parity_done`  out  1  parity byte has been captured.
- `low_packet_valid`  out  1  `packet_valid` fell during Load_data.
- `err`  out  1  parity mismatch for the last packet.

## Operation
Internal registers: `hdr` (DW), `full_hold` (DW), `int_parity` (DW), `pkt_parity` (DW). Priority is top-down within each list.
- Reset (`resetn`=0, async): `dout`, `hdr`, `full_hold`, `int_parity`, `pkt_parity` = 0; `parity_done`, `low_packet_valid`, `err` = 0.
- `hdr`: `detect_add && packet_valid && data_in[1:0]!=2'b11` -> `hdr <= data_in`; else hold.
- `dout`:
  - `lfd_state` -> `hdr`.
  - `ld_state && !fifo_full` -> `data_in`.
  - `laf_state` -> `full_hold`.
  - Otherwise hold.
- `full_hold`: `ld_state && fifo_full` -> `data_in` (byte that could not be written); else hold.
- `int_parity`:
  - `detect_add` -> 0.
  - `lfd_state` -> `int_parity ^ hdr`.
  - `ld_state && packet_valid && !full_state && !fifo_full` -> `^ data_in`.
  - `laf_state && !parity_done && !low_packet_valid` -> `^ full_hold`.
  - Otherwise hold.
- `pkt_parity`:
  - `detect_add` -> 0.
  - `ld_state && !packet_valid && !fifo_full` -> `data_in`.
  - `laf_state && low_packet_valid && !parity_done` -> `full_hold`.
- `parity_done`:
  - `detect_add` -> 0.
  - Set on either `pkt_parity` capture condition above.
  - Otherwise hold.
- `low_packet_valid`:
  - `rst_int_reg` -> 0.
  - `ld_state && !packet_valid` -> 1.
  - Otherwise hold.
- `err`:
  - `detect_add` -> 0.
  - `rst_int_reg && parity_done` -> `int_parity != pkt_parity`.
  - Otherwise hold (sticky until next header).
- Address 2'b11 headers: `hdr` is not updated, and no other register changes.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `dout` is valid one cycle after the strobe that loads it. The FSM `write_enb_reg` in that state lines up with `dout` on the following edge.
- Header appears on `dout` one cycle after `lfd_state`. Payload latency `data_in` -> `dout` is 1 cycle.
- Full handling: the byte present on the cycle `ld_state && fifo_full` goes to `full_hold`. It reappears on `dout` exactly one cycle after `laf_state`, with no loss and no duplication.
- `parity_done` and `low_packet_valid` rise the cycle after the qualifying strobe, in time for the FSM Load_after_full decision.
- `err` is valid the cycle after Check_parity_error and holds until the next `detect_add`.
- Simultaneous events:
  - `detect_add` with `rst_int_reg`: `detect_add` wins for `err`.
  - `resetn` asserted mid-packet: all registers clear immediately. The next packet needs a fresh header.

## Test plan
- Header 0x0D (len 3, addr 1), payload 0x11, 0x22, 0x33, parity 0x0D, with no full -> `dout` sequence 0x0D, 0x11, 0x22, 0x33, 0x0D; `parity_done`=1; `err`=0.
- Same packet with parity byte 0x0C -> `err`=1 after `rst_int_reg`; cleared by the next `detect_add`.
- `fifo_full` asserted when 0x22 arrives -> `full_hold`=0x22. After `laf_state`, `dout`=0x22 and `int_parity` still ends at 0x0D, so `err`=0.
- Full asserted on the parity byte -> `pkt_parity`=0x0D captured via `laf_state`; `parity_done` rises then.
- Header 0x0F (addr 3) with `detect_add` -> `hdr` unchanged; `dout` unchanged.
- `resetn` pulsed low asynchronously mid-payload -> all outputs are 0 within the same cycle, before the next clock edge.
